// File: rtl/apb3_param_router.sv
// APB3 address router: one master port fanned out to NUM_SLAVES peripherals by a PADDR field,
// with decode errors, a PREADY watchdog, and error accounting (counter + last failing address).
module apb3_param_router #(
   parameter int unsigned NUM_SLAVES     = 4,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned SEL_LSB        = 12,
   parameter int unsigned SLV_ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT        = 255
) (
   input  logic                             io_apb_PCLK,
   input  logic                             io_apb_PRESET,
   input  logic [ADDR_WIDTH-1:0]            io_apb_PADDR,
   input  logic                             io_apb_PSEL,
   input  logic                             io_apb_PENABLE,
   input  logic                             io_apb_PWRITE,
   input  logic [DATA_WIDTH-1:0]            io_apb_PWDATA,
   output logic                             io_apb_PREADY,
   output logic [DATA_WIDTH-1:0]            io_apb_PRDATA,
   output logic                             io_apb_PSLVERROR,
   output logic [SLV_ADDR_WIDTH-1:0]        s_PADDR,
   output logic [NUM_SLAVES-1:0]            s_PSEL,
   output logic                             s_PENABLE,
   output logic                             s_PWRITE,
   output logic [DATA_WIDTH-1:0]            s_PWDATA,
   input  logic [NUM_SLAVES-1:0]            s_PREADY,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_PRDATA,
   input  logic [NUM_SLAVES-1:0]            s_PSLVERROR,
   output logic [7:0]                       err_count,
   output logic [ADDR_WIDTH-1:0]            last_err_addr,
   output logic                             timeout_pulse
);

   localparam int unsigned FW = ADDR_WIDTH - SEL_LSB;
   localparam int unsigned IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned TW = 16;

   typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;

   state_t                r_state;
   logic [IW-1:0]         r_idx;
   logic                  r_decode_err;
   logic [TW-1:0]         r_timer;
   logic [7:0]            r_err_count;
   logic [ADDR_WIDTH-1:0] r_last_err_addr;
   logic                  r_timeout_pulse;

   logic [FW-1:0]         w_field;
   logic [31:0]           w_field_val;
   logic                  w_field_ok;
   logic                  w_setup;
   logic                  w_sel_phase;
   logic [DATA_WIDTH-1:0] w_rdata [NUM_SLAVES];
   logic                  w_slv_ready;
   logic                  w_slv_err;
   logic [DATA_WIDTH-1:0] w_slv_rdata;
   logic                  w_timer_exp;
   logic                  w_complete;
   logic                  w_err_done;

   assign w_field     = io_apb_PADDR[ADDR_WIDTH-1:SEL_LSB];
   assign w_field_val = 32'(w_field);
   assign w_field_ok  = (w_field_val < NUM_SLAVES);
   assign w_setup     = io_apb_PSEL & ~io_apb_PENABLE & (r_state == IDLE);
   assign w_sel_phase = w_setup | (r_state == ACCESS);

   // Live decode of the select field; ABORT and IDLE-without-setup never select.
   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
      assign s_PSEL[i]  = io_apb_PSEL & w_sel_phase & w_field_ok & (w_field_val == 32'(i));
      assign w_rdata[i] = s_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign s_PADDR   = io_apb_PADDR[SLV_ADDR_WIDTH+1:2];
   assign s_PWRITE  = io_apb_PWRITE;
   assign s_PWDATA  = io_apb_PWDATA;
   assign s_PENABLE = io_apb_PENABLE & (r_state == ACCESS) & ~r_decode_err;

   // Response path always uses the index captured at setup, not the live address.
   assign w_slv_ready = s_PREADY[r_idx];
   assign w_slv_err   = s_PSLVERROR[r_idx];
   assign w_slv_rdata = w_rdata[r_idx];
   assign w_timer_exp = (r_timer == TW'(TIMEOUT - 1));

   always_comb begin
      io_apb_PREADY    = 1'b1;
      io_apb_PRDATA    = '0;
      io_apb_PSLVERROR = 1'b0;
      case (r_state)
         ACCESS: begin
            if (r_decode_err) begin
               io_apb_PSLVERROR = 1'b1;
            end else begin
               io_apb_PREADY    = w_slv_ready;
               io_apb_PRDATA    = w_slv_rdata;
               io_apb_PSLVERROR = w_slv_err;
            end
         end
         ABORT:   io_apb_PSLVERROR = 1'b1;
         default: ;
      endcase
   end

   assign w_complete = ((r_state == ACCESS) & (r_decode_err | w_slv_ready)) | (r_state == ABORT);
   assign w_err_done = w_complete & io_apb_PSLVERROR;

   always_ff @(posedge io_apb_PCLK) begin
      if (io_apb_PRESET) begin
         r_state         <= IDLE;
         r_idx           <= '0;
         r_decode_err    <= 1'b0;
         r_timer         <= '0;
         r_err_count     <= '0;
         r_last_err_addr <= '0;
         r_timeout_pulse <= 1'b0;
      end else begin
         r_timeout_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_setup) begin
                  r_idx        <= IW'(w_field);
                  r_decode_err <= ~w_field_ok;
                  r_timer      <= '0;
                  r_state      <= ACCESS;
               end
            end
            ACCESS: begin
               // Slave ready wins over a coincident watchdog expiry.
               if (r_decode_err || w_slv_ready) begin
                  r_state <= IDLE;
               end else if (w_timer_exp) begin
                  r_state         <= ABORT;
                  r_timeout_pulse <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            ABORT:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         if (w_err_done) begin
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            r_last_err_addr <= io_apb_PADDR;
         end
      end
   end

   assign err_count     = r_err_count;
   assign last_err_addr = r_last_err_addr;
   assign timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_apb3_param_router.sv
// Scoreboard bench for apb3_param_router: driver queues expected responses, a forked monitor
// checks each completed transfer on the master port.
module tb_apb3_param_router;

   logic        clk;
   logic        rst;
   logic [15:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic [3:0]  s_paddr;
   logic [3:0]  s_psel;
   logic        s_penable;
   logic        s_pwrite;
   logic [31:0] s_pwdata;
   logic [3:0]  s_pready;
   logic [127:0] s_prdata;
   logic [3:0]  s_pslverr;
   logic [7:0]  err_count;
   logic [15:0] last_err_addr;
   logic        timeout_pulse;

   logic [31:0] sd [4];
   assign s_prdata = {sd[3], sd[2], sd[1], sd[0]};

   apb3_param_router #(
      .NUM_SLAVES(4), .ADDR_WIDTH(16), .SEL_LSB(12), .SLV_ADDR_WIDTH(4),
      .DATA_WIDTH(32), .TIMEOUT(8)
   ) dut (
      .io_apb_PCLK(clk), .io_apb_PRESET(rst), .io_apb_PADDR(paddr),
      .io_apb_PSEL(psel), .io_apb_PENABLE(penable), .io_apb_PWRITE(pwrite),
      .io_apb_PWDATA(pwdata), .io_apb_PREADY(pready), .io_apb_PRDATA(prdata),
      .io_apb_PSLVERROR(pslverr), .s_PADDR(s_paddr), .s_PSEL(s_psel),
      .s_PENABLE(s_penable), .s_PWRITE(s_pwrite), .s_PWDATA(s_pwdata),
      .s_PREADY(s_pready), .s_PRDATA(s_prdata), .s_PSLVERROR(s_pslverr),
      .err_count(err_count), .last_err_addr(last_err_addr), .timeout_pulse(timeout_pulse)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [15:0] waits;
      logic [3:0]  psel_wait;
      logic [3:0]  psel_done;
      logic        tpulse;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      int   waits;
      logic armed;
      exp_t e;
      waits = 0;
      armed = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            armed = 1'b0;
            waits = 0;
         end else if (psel && !penable) begin
            armed = 1'b1;
            waits = 0;
         end else if (armed && psel && penable) begin
            if (!pready) begin
               waits++;
               if (exp_q.size() > 0) chk("psel_wait", 64'(s_psel), 64'(exp_q[0].psel_wait));
            end else begin
               armed = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_completion", 64'(1), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  chk("prdata", 64'(prdata), 64'(e.rdata));
                  chk("pslverror", 64'(pslverr), 64'(e.err));
                  chk("wait_states", 64'(waits), 64'(e.waits));
                  chk("psel_done", 64'(s_psel), 64'(e.psel_done));
                  chk("timeout_pulse", 64'(timeout_pulse), 64'(e.tpulse));
               end
            end
         end
      end
   endtask

   // One transfer starting now (posedge+1); slv<0 means no slave responds, waits<0 means stuck.
   task automatic xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                       input int slv, input int waits, input logic [31:0] rd, input logic serr,
                       input logic [31:0] x_rdata, input logic x_err, input int x_waits,
                       input logic [3:0] x_psel_done, input logic x_tp);
      exp_t e;
      int   cnt;
      logic done;
      e.rdata     = x_rdata;
      e.err       = x_err;
      e.waits     = 16'(x_waits);
      e.psel_wait = (slv >= 0) ? 4'(1 << slv) : 4'b0000;
      e.psel_done = x_psel_done;
      e.tpulse    = x_tp;
      exp_q.push_back(e);
      paddr = addr; psel = 1'b1; penable = 1'b0; pwrite = wr; pwdata = wd;
      s_pready = 4'b0000; s_pslverr = 4'b0000;
      if (slv >= 0) sd[slv] = rd;
      @(posedge clk); #1;
      penable = 1'b1;
      cnt = 0;
      done = 1'b0;
      while (!done && cnt < 100) begin
         if (slv >= 0) begin
            s_pready[slv]  = (waits >= 0) && (cnt == waits);
            s_pslverr[slv] = serr;
         end
         @(negedge clk);
         done = pready;
         @(posedge clk); #1;
         cnt++;
      end
      if (!done) chk("xfer_bound", 64'(0), 64'(1));
      s_pready = 4'b0000;
      s_pslverr = 4'b0000;
   endtask

   initial begin
      rst = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
      s_pready = 4'b0000; s_pslverr = 4'b0000;
      for (int i = 0; i < 4; i++) sd[i] = 32'hBAD0_0000 | 32'(i);
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready", 64'(pready), 64'(1));
      chk("rst_prdata", 64'(prdata), 64'(0));
      chk("rst_pslverr", 64'(pslverr), 64'(0));
      chk("rst_s_psel", 64'(s_psel), 64'(0));
      chk("rst_s_penable", 64'(s_penable), 64'(0));
      chk("rst_err_count", 64'(err_count), 64'(0));
      chk("rst_last_err", 64'(last_err_addr), 64'(0));
      chk("rst_tpulse", 64'(timeout_pulse), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Write to slave1, zero wait states
      xfer(16'h1008, 1'b1, 32'h1234_5678, 1, 0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 4'b0010, 1'b0);
      chk("s_paddr_1008", 64'(s_paddr), 64'(2));
      chk("s_pwdata", 64'(s_pwdata), 64'(32'h1234_5678));
      chk("s_pwrite", 64'(s_pwrite), 64'(1));
      chk("err_count_w", 64'(err_count), 64'(0));

      // Read slave3 after 3 wait states
      xfer(16'h3004, 1'b0, 32'h0, 3, 3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 3, 4'b1000, 1'b0);
      chk("s_paddr_3004", 64'(s_paddr), 64'(1));

      // Reset while slave1 is stalling
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      paddr = 16'h1000; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_s_psel", 64'(s_psel), 64'(0));
      chk("midrst_s_penable", 64'(s_penable), 64'(0));
      chk("midrst_pready", 64'(pready), 64'(1));
      chk("midrst_prdata", 64'(prdata), 64'(0));
      chk("midrst_err_count", 64'(err_count), 64'(0));
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      xfer(16'h1004, 1'b1, 32'hA5A5_0001, 1, 1, 32'h0, 1'b0, 32'h0, 1'b0, 1, 4'b0010, 1'b0);

      // Unmapped index 7: immediate error, no slave selected
      xfer(16'h7000, 1'b0, 32'h0, -1, 0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 4'b0000, 1'b0);
      chk("decode_err_count", 64'(err_count), 64'(1));
      chk("decode_last_err", 64'(last_err_addr), 64'(16'h7000));

      // Slave0 stuck: 8 wait states then abort
      xfer(16'h0010, 1'b0, 32'h0, 0, -1, 32'h1111_2222, 1'b0, 32'h0, 1'b1, 8, 4'b0000, 1'b1);
      chk("tmo_err_count", 64'(err_count), 64'(2));
      chk("tmo_last_err", 64'(last_err_addr), 64'(16'h0010));
      chk("tmo_pulse_clear", 64'(timeout_pulse), 64'(0));
      // Back-to-back to slave2
      xfer(16'h2000, 1'b0, 32'h0, 2, 1, 32'h5A5A_1234, 1'b0, 32'h5A5A_1234, 1'b0, 1, 4'b0100, 1'b0);
      chk("after_tmo_count", 64'(err_count), 64'(2));

      // Ready on the final allowed cycle beats the watchdog
      xfer(16'h0020, 1'b0, 32'h0, 0, 7, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0, 7, 4'b0001, 1'b0);
      chk("coincide_count", 64'(err_count), 64'(2));

      // PENABLE with no preceding setup is ignored
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      paddr = 16'h1000; psel = 1'b1; penable = 1'b1; s_pready = 4'b0010;
      chk("nosetup_s_psel", 64'(s_psel), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      chk("nosetup_s_psel2", 64'(s_psel), 64'(0));
      chk("nosetup_s_penable", 64'(s_penable), 64'(0));
      psel = 1'b0; penable = 1'b0; s_pready = 4'b0000;
      @(posedge clk); #1;

      // Repeated slave errors saturate the counter
      for (int i = 0; i < 300; i++) begin
         xfer(16'h2010, 1'b0, 32'h0, 2, 0, 32'(i), 1'b1, 32'(i), 1'b1, 0, 4'b0100, 1'b0);
         if (i == 9) chk("slverr_count_10", 64'(err_count), 64'(12));
      end
      chk("slverr_sat", 64'(err_count), 64'(255));
      chk("slverr_last", 64'(last_err_addr), 64'(16'h2010));

      psel = 1'b0; penable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
